cp_insert: RTL
==============

Name: cp_insert

Overview:
- Cyclic-prefix insertion unit. Sits directly downstream of the transmit power fix unit and upstream of the DAC interface.
- Collects each N_FFT-sample time-domain OFDM symbol and emits it as N_CP prefix samples followed by the full N_FFT-sample body.
- The prefix samples are a copy of the last N_CP samples of the symbol.
- Ping-pong buffering lets the next symbol be written while the current one is read out.

Parameters:
- N_FFT, 512, samples per OFDM symbol (power of 2)
- N_CP, 128, cyclic-prefix length, 1 <= N_CP < N_FFT
- DW, 12, sample width per I/Q component (two's complement)

Ports:
- clk  input  1  working clock
- rst  input  1  asynchronous reset, active-high
- di_re  input  DW  input sample, real part (signed)
- di_im  input  DW  input sample, imaginary part (signed)
- di_vld  input  1  input sample valid; one sample per cycle while high
- do_re  output  DW  output sample, real part (signed)
- do_im  output  DW  output sample, imaginary part (signed)
- do_vld  output  1  output sample valid
- do_sos  output  1  start-of-symbol; high with the first prefix sample only
- ovf  output  1  sticky overflow flag; cleared only by rst

Behaviour:
- Reset (async, rst=1): do_re=0, do_im=0, do_vld=0, do_sos=0, ovf=0. Both banks marked empty, write bank=0, read bank=0, write counter=0, read FSM=IDLE. Reset mid-symbol discards all partial and buffered data.
- Storage: two banks of N_FFT x 2*DW, synchronous-read RAM with 1-cycle read latency. Bank has a full flag.
- Write side:
  - Every cycle with di_vld=1 writes {di_re,di_im} to write bank at address wcnt, then wcnt increments.
  - Gaps in di_vld are allowed; a symbol is N_FFT valid samples, not N_FFT consecutive cycles.
  - When wcnt wraps from N_FFT-1 to 0: set full flag of write bank and toggle write bank.
- Write overflow:
  - If di_vld=1 with wcnt=0 and the write bank is still full, set ovf=1.
  - Drop that sample and the next N_FFT-1 valid samples (whole symbol discarded, counted but not written). Buffered data stays intact.
- Read FSM states and transitions:
  - IDLE -> CP when the read bank's full flag is set.
  - CP: read addresses N_FFT-N_CP .. N_FFT-1 in consecutive cycles. After the last address -> BODY.
  - BODY: read addresses 0 .. N_FFT-1 in consecutive cycles. On the last address, clear the read bank's full flag and toggle the read bank.
  - After BODY: if the new read bank is full -> CP (back-to-back symbols, no idle cycle); else -> IDLE.
- Output timing:
  - do_re/do_im/do_vld are registered, 2 cycles after the read address is issued.
  - Each symbol produces exactly N_FFT+N_CP consecutive do_vld=1 cycles.
  - do_sos aligns with the first CP sample.
  - Whenever do_vld=0, do_re=do_im=0.
- Latency: last input sample of a symbol written at edge t → FSM enters CP at edge t+1 → first do_vld at edge t+3 (if read side IDLE).
- Simultaneous events:
  - Write into bank X's last address in the same cycle the read side clears bank Y: both take effect independently.
  - The full flag set by the write side and the clear by the read side never target the same bank in the same cycle.
  - Write bank == read bank while that bank is being read is legal only if it is not full, which cannot occur; the flags guarantee exclusion.
- Throughput: sustained input must average at most N_FFT valid samples per N_FFT+N_CP cycles; otherwise ovf is set.
- Arithmetic: none; data passes bit-exact.

Test Plan:
- Single symbol, N_FFT=512, N_CP=128, di_re=k, di_im=-k for k=0..511, contiguous → do_vld high 640 cycles starting 3 cycles after last input. Output re = 384..511 then 0..511. do_sos high on first cycle only. ovf=0.
- Input with random 1-3 cycle gaps in di_vld, same data → output identical to the contiguous case. Output is contiguous with no gaps.
- Three symbols, each 512 contiguous samples followed by 128 idle cycles → 3×640 output samples back-to-back. do_sos pulses exactly every 640 cycles. Correct per-symbol data. ovf=0.
- Four symbols fully contiguous (2048 valid cycles) → third symbol finds both banks full, so ovf=1. Symbols 1, 2 and 4 are output intact. Symbol 3 never appears.
- Assert rst for 1 cycle mid-way through the CP phase → do_vld/do_sos/ovf go 0 asynchronously. The next full symbol input is output normally with 3-cycle latency.
- Edge values: di_re=2047, di_im=-2048 for all samples → output bit-exact with no sign corruption.

Source files
------------

// File: rtl/cp_insert_if.sv
// Sample-stream bundle for the cyclic-prefix inserter: the input stream,
// the framed output stream and the sticky overflow flag.
interface cp_insert_if #(
  parameter int DW = 12
);
  logic signed [DW-1:0] di_re;
  logic signed [DW-1:0] di_im;
  logic                 di_vld;
  logic signed [DW-1:0] do_re;
  logic signed [DW-1:0] do_im;
  logic                 do_vld;
  logic                 do_sos;
  logic                 ovf;

  // Inserter side: consumes the input stream, produces the output stream.
  modport slave (
    input  di_re, di_im, di_vld,
    output do_re, do_im, do_vld, do_sos, ovf
  );

  // Source/sink side: drives samples in, observes the framed stream.
  modport master (
    output di_re, di_im, di_vld,
    input  do_re, do_im, do_vld, do_sos, ovf
  );
endinterface

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion. Each N_FFT-sample symbol is collected into one
// of two ping-pong banks, then replayed as its last N_CP samples followed
// by the full body. Data is passed bit-exact.
module cp_insert #(
  parameter int N_FFT = 512,
  parameter int N_CP  = 128,
  parameter int DW    = 12
) (
  input  logic       clk,
  input  logic       rst,
  cp_insert_if.slave bus
);
  localparam int            AW       = $clog2(N_FFT);
  localparam logic [AW-1:0] LAST     = AW'(N_FFT - 1);
  localparam logic [AW-1:0] CP_START = AW'(N_FFT - N_CP);

  typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

  // Write side
  logic [AW-1:0]   wcnt;
  logic            wbank;
  logic            drop_q;
  logic            drop_now;
  logic            wr_en;
  logic            wr_last;
  logic            ovf_q;
  logic [1:0]      full;
  logic [1:0]      full_set;
  logic [1:0]      full_clr;

  // Read side
  state_t          state, state_nx;
  logic [AW-1:0]   rd_addr_p0, rd_addr_nx;
  logic            rbank, rbank_nx;
  logic            rd_clr;
  logic            rd_vld_p0, rd_sos_p0;
  logic            rd_vld_p1, rd_sos_p1;
  logic [2*DW-1:0] rdata_p1;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [2*DW-1:0] mem [2*N_FFT];

  // A symbol is dropped as a whole when its first sample finds the write
  // bank still waiting to be read; the decision is held for the symbol.
  assign drop_now = (wcnt == '0) ? full[wbank] : drop_q;
  assign wr_en    = bus.di_vld && !drop_now;
  assign wr_last  = bus.di_vld && (wcnt == LAST);

  // Writer and reader always address different banks when they set and
  // clear, so both updates can land on the same edge.
  assign full_set = (wr_last && !drop_now) ? (2'b01 << wbank) : 2'b00;
  assign full_clr = rd_clr ? (2'b01 << rbank) : 2'b00;

  assign bus.ovf  = ovf_q;

  // Write counter, bank toggle, drop tracking and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt   <= '0;
      wbank  <= 1'b0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.di_vld) begin
      wcnt   <= wcnt + AW'(1);
      drop_q <= drop_now;
      if ((wcnt == '0) && full[wbank]) ovf_q <= 1'b1;
      if (wr_last && !drop_now) wbank <= ~wbank;
    end
  end

  // Bank-full flags: set by the writer on symbol completion, cleared by
  // the reader after the last body address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= 2'b00;
    else     full <= (full | full_set) & ~full_clr;
  end

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank, wcnt}] <= {bus.di_re, bus.di_im};
  end

  // Read FSM state, issued address and current read bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr_p0 <= '0;
      rbank      <= 1'b0;
    end else begin
      state      <= state_nx;
      rd_addr_p0 <= rd_addr_nx;
      rbank      <= rbank_nx;
    end
  end

  // Next-state logic: prefix addresses, then body addresses, then either
  // chain straight into the other bank or fall back to idle.
  always_comb begin
    state_nx   = state;
    rd_addr_nx = rd_addr_p0;
    rbank_nx   = rbank;
    rd_clr     = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          state_nx   = CP;
          rd_addr_nx = CP_START;
        end
      end
      CP: begin
        if (rd_addr_p0 == LAST) begin
          state_nx   = BODY;
          rd_addr_nx = '0;
        end else begin
          rd_addr_nx = rd_addr_p0 + AW'(1);
        end
      end
      BODY: begin
        if (rd_addr_p0 == LAST) begin
          rd_clr   = 1'b1;
          rbank_nx = ~rbank;
          if (full[~rbank]) begin
            state_nx   = CP;
            rd_addr_nx = CP_START;
          end else begin
            state_nx   = IDLE;
          end
        end else begin
          rd_addr_nx = rd_addr_p0 + AW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: address issued this cycle
  assign rd_vld_p0 = (state != IDLE);
  assign rd_sos_p0 = (state == CP) && (rd_addr_p0 == CP_START);

  // p0 -> p1: synchronous RAM read of the issued address.
  always_ff @(posedge clk) begin
    rdata_p1 <= mem[{rbank, rd_addr_p0}];
  end

  // p0 -> p1: valid and start-of-symbol follow the read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p1 <= 1'b0;
      rd_sos_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_vld_p0;
      rd_sos_p1 <= rd_sos_p0;
    end
  end

  // p1 -> p2: registered outputs, data forced to zero when not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.do_re  <= '0;
      bus.do_im  <= '0;
      bus.do_vld <= 1'b0;
      bus.do_sos <= 1'b0;
    end else begin
      bus.do_vld <= rd_vld_p1;
      bus.do_sos <= rd_sos_p1;
      bus.do_re  <= rd_vld_p1 ? rdata_p1[2*DW-1:DW] : '0;
      bus.do_im  <= rd_vld_p1 ? rdata_p1[DW-1:0]    : '0;
    end
  end
endmodule
